// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressed data memory behind a valid/ready request port.
// It supports 1/2/4/8-byte accesses, big-endian byte order within an access
// (the lowest address holds the most-significant byte) and a fixed
// programmable wait of LATENCY cycles before the access commits. Misaligned
// accesses and accesses running past DEPTH are rejected with rsp_err.
//
// Ports
//   clk        clock, all state changes on posedge
//   reset      asynchronous, active-high
//   req_valid  request present
//   req_ready  controller can accept (high only in IDLE)
//   req_we     1 = write, 0 = read
//   req_size   access size code: N = 1 << req_size bytes
//   req_addr   byte address of the access
//   req_wdata  write data, right-justified (low N bytes used)
//   rsp_valid  one-cycle response pulse
//   rsp_rdata  read data, zero-extended and right-justified
//   rsp_err    access rejected (misaligned or out of range)
//   busy       controller not idle
module dmem_ctrl #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int DEPTH   = 16384,
  parameter int LATENCY = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LANES = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [7:0]        mem_q [DEPTH];

  logic              accept;
  logic              commit;
  logic [3:0]        nbytes;
  logic [2:0]        align_mask;
  logic              misalign;
  logic [ADDR_W:0]   end_addr;
  logic              range_err;
  logic              err;
  logic [IDX_W-1:0]  idx_base;
  logic [DATA_W-1:0] rd_val;

  // Byte i (in address order) of an n-byte right-justified value.
  function automatic logic [7:0] lane_of(input logic [DATA_W-1:0] v,
                                         input logic [3:0] n, input int i);
    logic [DATA_W-1:0] s;
    s = v >> (8 * (int'(n) - 1 - i));
    return s[7:0];
  endfunction

  assign accept = req_valid && (state_q == S_IDLE);
  // Reset is folded in so a reset coinciding with the commit edge can never
  // leave a half-finished write behind.
  assign commit = (state_q == S_WAIT) && (cnt_q == 3'd0) && !reset;

  assign nbytes     = 4'd1 << size_q;
  assign align_mask = 3'(nbytes - 4'd1);
  assign misalign   = |(addr_q[2:0] & align_mask);
  // One extra bit so an address near the top of the space cannot wrap past
  // the range check.
  assign end_addr   = {1'b0, addr_q} + (ADDR_W+1)'(nbytes);
  assign range_err  = end_addr > (ADDR_W+1)'(DEPTH);
  assign err        = misalign | range_err;
  assign idx_base   = addr_q[IDX_W-1:0];

  // Lowest address first, shifting left, so it ends up most significant.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < LANES; i++) begin
      if (4'(i) < nbytes) begin
        rd_val = {rd_val[DATA_W-9:0], mem_q[idx_base + IDX_W'(i)]};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_WAIT;
          cnt_d   = 3'(LATENCY);
        end
      end
      S_WAIT: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit) begin
        err_q   <= err;
        rdata_q <= (err || we_q) ? '0 : rd_val;
      end
    end
  end

  // Request capture: the access uses only what was present at the accept edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Storage is never reset; only the N addressed bytes of a clean write change.
  always_ff @(posedge clk) begin
    if (commit && we_q && !err) begin
      for (int i = 0; i < LANES; i++) begin
        if (4'(i) < nbytes) begin
          mem_q[idx_base + IDX_W'(i)] <= lane_of(wdata_q, nbytes, i);
        end
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
